stream_fifo: RTL and testbench



---
 rtl/stream_fifo_pkg.sv | 44 ++++
 rtl/stream_fifo_ptr.sv | 35 +++
 rtl/stream_fifo.sv | 161 ++++++++++++++++
 tb/tb_stream_fifo.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/stream_fifo_pkg.sv
// stream_fifo_pkg
// Shared types, default parameters and helper functions for stream_fifo.
//   calc_cw     : width of count/threshold fields for a given depth
//   calc_pw     : width of a pointer that indexes 0..depth-1
//   calc_status : decode of the status flags from a word count
//   status_t    : packed status bundle (empty, full, almost_full, almost_empty)
// Optional feature macro used by the top: STREAM_FIFO_PEAK_EN.
package stream_fifo_pkg;

    localparam int unsigned DEF_WIDTH = 8;
    localparam int unsigned DEF_DEPTH = 8;
    localparam int unsigned DEF_AE_TH = 1;

    typedef struct packed {
        logic empty;
        logic full;
        logic almost_full;
        logic almost_empty;
    } status_t;

    // Count field must represent 0..depth inclusive.
    function automatic int unsigned calc_cw(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

    // Pointer field covers 0..depth-1; keep at least one bit.
    function automatic int unsigned calc_pw(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Threshold compares naturally give af_th==0 -> 1 and af_th>depth -> 0.
    function automatic status_t calc_status(input int unsigned count,
                                            input int unsigned depth,
                                            input int unsigned ae_th,
                                            input int unsigned af_th);
        status_t s;
        s.empty        = (count == 0);
        s.full         = (count == depth);
        s.almost_full  = (count >= af_th);
        s.almost_empty = (count <= ae_th);
        return s;
    endfunction

endpackage

// File: rtl/stream_fifo_ptr.sv
// stream_fifo_ptr
// Pointer counter that wraps explicitly from DEPTH-1 to 0 (any depth).
// Ports:
//   i_clk   : clock, rising edge
//   i_rst   : synchronous active-high reset
//   i_clear : synchronous flush, same effect as reset
//   i_inc   : advance pointer by one
//   o_ptr   : current pointer value, 0..DEPTH-1
module stream_fifo_ptr
    import stream_fifo_pkg::*;
#(
    parameter int unsigned DEPTH = DEF_DEPTH,
    parameter int unsigned PW    = calc_pw(DEPTH)
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_clear,
    input  logic          i_inc,
    output logic [PW-1:0] o_ptr
);

    // Pointer register with explicit wrap at the last entry.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_clear) begin
            o_ptr <= '0;
        end else if (i_inc) begin
            if (o_ptr == PW'(DEPTH - 1)) begin
                o_ptr <= '0;
            end else begin
                o_ptr <= o_ptr + PW'(1);
            end
        end
    end

endmodule

// File: rtl/stream_fifo.sv
// stream_fifo
// Synchronous valid/ready FIFO with arbitrary depth, programmable
// almost-full threshold, almost-empty status and sticky protocol-error flags.
// Optional: define STREAM_FIFO_PEAK_EN to add o_peak_count (high-water mark).
// Ports:
//   i_clk, i_rst          : clock, synchronous active-high reset
//   i_clear               : synchronous flush of contents and sticky flags
//   i_af_th               : almost-full threshold (count >= i_af_th)
//   i_valid/o_ready/i_data: producer side
//   o_valid/i_ready/o_data: consumer side (o_data = head of queue)
//   o_word_count          : stored word count
//   o_empty/o_full/o_almost_full/o_almost_empty : status flags
//   o_err_drop            : sticky, producer dropped/changed a stalled word
//   o_err_underflow       : sticky, consumer ready while FIFO empty
//   o_peak_count          : (STREAM_FIFO_PEAK_EN only) peak word count
module stream_fifo
    import stream_fifo_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned DEPTH = DEF_DEPTH,
    parameter int unsigned AE_TH = DEF_AE_TH,
    parameter int unsigned CW    = calc_cw(DEPTH)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_clear,
    input  logic [CW-1:0]    i_af_th,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_data,
    output logic [CW-1:0]    o_word_count,
    output logic             o_empty,
    output logic             o_full,
    output logic             o_almost_full,
    output logic             o_almost_empty,
    output logic             o_err_drop,
    output logic             o_err_underflow
`ifdef STREAM_FIFO_PEAK_EN
    ,
    output logic [CW-1:0]    o_peak_count
`endif
);

    localparam int unsigned PW = calc_pw(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    count_d;
    logic             push;
    logic             pop;
    status_t          status;

    logic             stall_q;
    logic [WIDTH-1:0] data_q;
    logic             drop_det;
    logic             under_det;
    logic             err_drop_q;
    logic             err_under_q;

    // Status decode from the registered count; almost-full follows i_af_th live.
    assign status = calc_status(32'(count_q), DEPTH, AE_TH, 32'(i_af_th));

    assign o_empty        = status.empty;
    assign o_full         = status.full;
    assign o_almost_full  = status.almost_full;
    assign o_almost_empty = status.almost_empty;
    assign o_ready        = !status.full;
    assign o_valid        = !status.empty;
    assign o_word_count   = count_q;
    assign o_data         = mem[rd_ptr];

    // Handshakes; a cycle with i_clear discards both sides.
    assign push = i_valid && o_ready && !i_clear;
    assign pop  = o_valid && i_ready && !i_clear;

    stream_fifo_ptr #(
        .DEPTH (DEPTH),
        .PW    (PW)
    ) u_wr_ptr (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_clear (i_clear),
        .i_inc   (push),
        .o_ptr   (wr_ptr)
    );

    stream_fifo_ptr #(
        .DEPTH (DEPTH),
        .PW    (PW)
    ) u_rd_ptr (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_clear (i_clear),
        .i_inc   (pop),
        .o_ptr   (rd_ptr)
    );

    // Storage array; contents are intentionally not reset.
    always_ff @(posedge i_clk) begin
        if (push) begin
            mem[wr_ptr] <= i_data;
        end
    end

    // Next word count.
    always_comb begin
        count_d = count_q;
        if (i_clear) begin
            count_d = '0;
        end else if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end
    end

    // A stalled word must stay valid with unchanged data until accepted.
    assign drop_det  = stall_q && (!i_valid || (i_data != data_q));
    assign under_det = i_ready && !o_valid;

    // Count, stall history and sticky error flags.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_clear) begin
            count_q     <= '0;
            stall_q     <= 1'b0;
            data_q      <= '0;
            err_drop_q  <= 1'b0;
            err_under_q <= 1'b0;
        end else begin
            count_q     <= count_d;
            stall_q     <= i_valid && !o_ready;
            data_q      <= i_data;
            err_drop_q  <= err_drop_q | drop_det;
            err_under_q <= err_under_q | under_det;
        end
    end

    assign o_err_drop      = err_drop_q;
    assign o_err_underflow = err_under_q;

`ifdef STREAM_FIFO_PEAK_EN
    logic [CW-1:0] peak_q;

    // High-water mark of the word count.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_clear) begin
            peak_q <= '0;
        end else if (count_d > peak_q) begin
            peak_q <= count_d;
        end
    end

    assign o_peak_count = peak_q;
`endif

endmodule

// File: tb/tb_stream_fifo.sv
// tb_stream_fifo
// Directed bench for stream_fifo: a DEPTH=8 instance for handshake, flag and
// error-flag behaviour and a DEPTH=5 instance for pointer wrap ordering.
module tb_stream_fifo;

    logic clk;
    logic rst;
    logic clear;

    // DEPTH=8 instance signals
    logic [3:0] af8;
    logic       v8, r8;
    logic [7:0] d8;
    logic       or8, ov8;
    logic [7:0] od8;
    logic [3:0] cnt8;
    logic       emp8, ful8, af_o8, ae_o8, edrop8, eund8;

    // DEPTH=5 instance signals
    logic [2:0] af5;
    logic       v5, r5;
    logic [7:0] d5;
    logic       or5, ov5;
    logic [7:0] od5;
    logic [2:0] cnt5;
    logic       emp5, ful5, af_o5, ae_o5, edrop5, eund5;

`ifdef STREAM_FIFO_PEAK_EN
    logic [3:0] peak8;
    logic [2:0] peak5;
`endif

    int total = 0;
    int bad   = 0;

    stream_fifo #(.WIDTH(8), .DEPTH(8), .AE_TH(1)) u8 (
        .i_clk           (clk),
        .i_rst           (rst),
        .i_clear         (clear),
        .i_af_th         (af8),
        .i_valid         (v8),
        .o_ready         (or8),
        .i_data          (d8),
        .o_valid         (ov8),
        .i_ready         (r8),
        .o_data          (od8),
        .o_word_count    (cnt8),
        .o_empty         (emp8),
        .o_full          (ful8),
        .o_almost_full   (af_o8),
        .o_almost_empty  (ae_o8),
        .o_err_drop      (edrop8),
        .o_err_underflow (eund8)
`ifdef STREAM_FIFO_PEAK_EN
        ,
        .o_peak_count    (peak8)
`endif
    );

    stream_fifo #(.WIDTH(8), .DEPTH(5), .AE_TH(1)) u5 (
        .i_clk           (clk),
        .i_rst           (rst),
        .i_clear         (clear),
        .i_af_th         (af5),
        .i_valid         (v5),
        .o_ready         (or5),
        .i_data          (d5),
        .o_valid         (ov5),
        .i_ready         (r5),
        .o_data          (od5),
        .o_word_count    (cnt5),
        .o_empty         (emp5),
        .o_full          (ful5),
        .o_almost_full   (af_o5),
        .o_almost_empty  (ae_o5),
        .o_err_drop      (edrop5),
        .o_err_underflow (eund5)
`ifdef STREAM_FIFO_PEAK_EN
        ,
        .o_peak_count    (peak5)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; clear = 1'b0;
        af8 = 4'd6; v8 = 1'b0; r8 = 1'b0; d8 = 8'h00;
        af5 = 3'd5; v5 = 1'b0; r5 = 1'b0; d5 = 8'h00;
        step();
        step();
        rst = 1'b0;

        // Reset state
        chk("rst_ready", or8, 1);
        chk("rst_valid", ov8, 0);
        chk("rst_empty", emp8, 1);
        chk("rst_full", ful8, 0);
        chk("rst_ae", ae_o8, 1);
        chk("rst_af", af_o8, 0);
        chk("rst_count", cnt8, 0);
        chk("rst_err_drop", edrop8, 0);
        chk("rst_err_under", eund8, 0);

        // Threshold 0 forces almost-full
        af8 = 4'd0; #1;
        chk("af_th0", af_o8, 1);
        af8 = 4'd6; #1;
        chk("af_th6_empty", af_o8, 0);

        // Fill with 0x01..0x08
        for (int i = 1; i <= 8; i++) begin
            v8 = 1'b1; d8 = 8'(i);
            step();
            chk("fill_count", cnt8, 32'(i));
            chk("fill_af", af_o8, (i >= 6) ? 32'd1 : 32'd0);
            chk("fill_ae", ae_o8, (i <= 1) ? 32'd1 : 32'd0);
        end
        chk("full_flag", ful8, 1);
        chk("full_ready", or8, 0);
        chk("full_head", od8, 8'h01);

        // Threshold above DEPTH forces almost-full low
        af8 = 4'd9; #1;
        chk("af_th9", af_o8, 0);
        af8 = 4'd6; #1;

        // Full with push+pop attempt: pop happens, push refused
        d8 = 8'h09; r8 = 1'b1;
        step();
        chk("fullpp_count", cnt8, 7);
        chk("fullpp_head", od8, 8'h02);
        chk("fullpp_full", ful8, 0);

        // Stalled word 0x09 held stable is now accepted without error
        r8 = 1'b0;
        step();
        chk("retry_count", cnt8, 8);
        v8 = 1'b0;
        step();
        chk("retry_err_drop", edrop8, 0);

        // Drain, order 0x02..0x09
        r8 = 1'b1;
        for (int k = 0; k < 8; k++) begin
            chk("drain_head", od8, 32'(k + 2));
            step();
        end
        r8 = 1'b0;
        chk("drain_empty", emp8, 1);
        chk("drain_count", cnt8, 0);
        chk("drain_err_under", eund8, 0);

        // One-cycle latency, no bypass
        v8 = 1'b1; d8 = 8'hAA; #1;
        chk("lat_no_bypass", ov8, 0);
        step();
        chk("lat_valid", ov8, 1);
        chk("lat_data", od8, 8'hAA);
        chk("lat_count", cnt8, 1);
        v8 = 1'b0; r8 = 1'b1;
        step();
        r8 = 1'b0;
        chk("lat_empty", emp8, 1);
        chk("lat_valid_lo", ov8, 0);

        // Stability violation while full
        for (int i = 0; i < 8; i++) begin
            v8 = 1'b1; d8 = 8'(8'h20 + i);
            step();
        end
        chk("drop_full", ful8, 1);
        d8 = 8'h10;
        step();
        chk("drop_stall", edrop8, 0);
        d8 = 8'h11;
        step();
        chk("drop_set", edrop8, 1);
        v8 = 1'b0;
        step();
        chk("drop_sticky1", edrop8, 1);
        step();
        chk("drop_sticky2", edrop8, 1);

        // Clear flushes contents and flags
        clear = 1'b1;
        step();
        clear = 1'b0;
        chk("clr_count", cnt8, 0);
        chk("clr_empty", emp8, 1);
        chk("clr_full", ful8, 0);
        chk("clr_err_drop", edrop8, 0);
        chk("clr_ready", or8, 1);

        // Underflow sticky, cleared by reset
        r8 = 1'b1;
        step();
        r8 = 1'b0;
        chk("under_set", eund8, 1);
        step();
        chk("under_sticky", eund8, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("under_rst", eund8, 0);

        // DEPTH=5 streaming: prime with 2 words, then 20 push+pop cycles
        v5 = 1'b1; d5 = 8'h00;
        step();
        d5 = 8'h01;
        step();
        chk("d5_prime_count", cnt5, 2);
        r5 = 1'b1;
        for (int k = 0; k < 20; k++) begin
            d5 = 8'(k + 2);
            chk("d5_head", od5, 32'(k));
            step();
            chk("d5_count", cnt5, 2);
        end
        v5 = 1'b0; r5 = 1'b0;
        chk("d5_err_drop", edrop5, 0);
        chk("d5_err_under", eund5, 0);

`ifdef STREAM_FIFO_PEAK_EN
        // High-water mark
        v8 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            d8 = 8'(i);
            step();
        end
        v8 = 1'b0; r8 = 1'b1;
        repeat (5) step();
        r8 = 1'b0; v8 = 1'b1;
        repeat (2) step();
        v8 = 1'b0;
        chk("peak_val", peak8, 5);
        chk("peak_count", cnt8, 2);
        clear = 1'b1;
        step();
        clear = 1'b0;
        chk("peak_clr", peak8, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
